// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and default sizes for the parallel-in serial-out stream
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int PISO_DATA_W = 8;
    localparam int PISO_DEPTH  = 8;

endpackage

// File: rtl/piso_out_stream.sv
// rtl/piso_out_stream.sv - parallel word in, DEPTH serial beats out over a valid/ready stream
// Define PISO_OUT_B2B_EN to accept the next word on the last-beat handshake with no bubble.
module piso_out_stream
    import piso_pkg::*;
#(
    parameter int DATA_W    = PISO_DATA_W,
    parameter int DEPTH     = PISO_DEPTH,
    parameter int LSB_FIRST = 1
) (
    input  logic                    CLKEXT,
    input  logic                    CLR_PISO,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DEPTH*DATA_W-1:0] load_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last
);

    localparam int WORD_W = DEPTH * DATA_W;
    localparam int CNT_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    piso_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;

    logic [DATA_W-1:0] head;
    logic [WORD_W-1:0] shifted;
    logic              load_fire;
    logic              beat_fire;

    // The element due next always sits at the output end; the far end is zero-filled.
    always_comb begin
        head    = '0;
        shifted = '0;
        if (LSB_FIRST != 0) begin
            head    = sreg_q[DATA_W-1:0];
            shifted = sreg_q >> DATA_W;
        end else begin
            head    = sreg_q[WORD_W-1 -: DATA_W];
            shifted = sreg_q << DATA_W;
        end
    end

    always_comb begin
        out_valid = (state_q == SHIFT);
        out_last  = out_valid && (cnt_q == CNT_LAST);
        out_data  = out_valid ? head : '0;
`ifdef PISO_OUT_B2B_EN
        load_ready = !CLR_PISO && ((state_q == IDLE) || (out_last && out_ready));
`else
        load_ready = !CLR_PISO && (state_q == IDLE);
`endif
        load_fire = load_valid && load_ready;
        beat_fire = out_valid && out_ready && !CLR_PISO;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        if (beat_fire) begin
            sreg_d = shifted;
            if (out_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A load on the last-beat handshake overrides the return to IDLE.
        if (load_fire) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = load_data;
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (CLR_PISO) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: tb/tb_piso_out_stream.sv
// tb/tb_piso_out_stream.sv - self-checking bench for piso_out_stream (LSB-first and MSB-first instances)
module tb_piso_out_stream;

    localparam int W = 8;
    localparam int D = 8;
`ifdef PISO_OUT_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           clr, lv, ordy;
    logic [D*W-1:0] ld;
    logic           lr_a, ov_a, ol_a, lr_b, ov_b, ol_b;
    logic [W-1:0]   od_a, od_b;

    piso_out_stream #(.DATA_W(W), .DEPTH(D), .LSB_FIRST(1)) dut_a (
        .CLKEXT(clk), .CLR_PISO(clr), .load_valid(lv), .load_ready(lr_a), .load_data(ld),
        .out_valid(ov_a), .out_ready(ordy), .out_data(od_a), .out_last(ol_a)
    );

    piso_out_stream #(.DATA_W(W), .DEPTH(D), .LSB_FIRST(0)) dut_b (
        .CLKEXT(clk), .CLR_PISO(clr), .load_valid(lv), .load_ready(lr_b), .load_data(ld),
        .out_valid(ov_b), .out_ready(ordy), .out_data(od_b), .out_last(ol_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference: a held word plus the index of the next beat to be delivered.
    bit             m_held = 1'b0;
    logic [D*W-1:0] m_word = '0;
    int             m_k = 0;

    function automatic logic [W-1:0] m_elem(bit lsb);
        int idx;
        if (!m_held) return '0;
        idx = lsb ? m_k : D - 1 - m_k;
        return m_word[idx*W +: W];
    endfunction

    function automatic bit m_last();
        return m_held && (m_k == D - 1);
    endfunction

    function automatic bit m_lready();
        return !clr && (!m_held || (B2B && m_last() && ordy));
    endfunction

    function automatic logic [D*W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        bit lr;
        lr = m_lready();
        @(posedge clk);
        if (clr) begin
            m_held = 1'b0;
            m_k    = 0;
        end else begin
            if (m_held && ordy) begin
                if (m_k == D - 1) m_held = 1'b0;
                else m_k++;
            end
            if (lv && lr) begin
                m_held = 1'b1;
                m_word = ld;
                m_k    = 0;
            end
        end
        #2;
    endtask

    task automatic test_reset();
        clr = 1'b1; lv = 1'b1; ordy = 1'b1; ld = rand_word();
        step();
        step();
        #1;
        checks++;
        if ({ov_a, od_a, ol_a, lr_a, ov_b, od_b, ol_b, lr_b} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got a=%b/%h/%b/%b b=%b/%h/%b/%b exp all zero",
                     ov_a, od_a, ol_a, lr_a, ov_b, od_b, ol_b, lr_b);
        end
        clr = 1'b0; lv = 1'b0;
        #1;
        checks++;
        if (lr_a !== 1'b1 || lr_b !== 1'b1 || ov_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got lr=%b/%b ov=%b exp lr=1/1 ov=0", lr_a, lr_b, ov_a);
        end
        step();
    endtask

    task automatic test_order();
        lv = 1'b1; ordy = 1'b1; ld = 64'h0706050403020100;
        #1;
        checks++;
        if (lr_a !== 1'b1) begin
            failures++;
            $display("FAIL order_load_ready got %b exp 1", lr_a);
        end
        step();
        lv = 1'b0;
        for (int k = 0; k < D; k++) begin
            #1;
            checks++;
            if (ov_a !== 1'b1 || od_a !== 8'(k) || ol_a !== (k == D - 1) ||
                ov_b !== 1'b1 || od_b !== 8'(D - 1 - k) || ol_b !== (k == D - 1)) begin
                failures++;
                $display("FAIL order_beat%0d got a=%b/%h/%b b=%b/%h/%b exp a=1/%h/%b b=1/%h/%b",
                         k, ov_a, od_a, ol_a, ov_b, od_b, ol_b, 8'(k), k == D - 1, 8'(D - 1 - k), k == D - 1);
            end
            step();
        end
        #1;
        checks++;
        if (ov_a !== 1'b0 || lr_a !== 1'b1 || ol_a !== 1'b0 || od_a !== 8'h00) begin
            failures++;
            $display("FAIL order_after got ov=%b lr=%b last=%b d=%h exp 0/1/0/00", ov_a, lr_a, ol_a, od_a);
        end
    endtask

    task automatic test_stall();
        logic [D*W-1:0] w;
        int beat;
        w = rand_word();
        lv = 1'b1; ordy = 1'b1; ld = w;
        step();
        lv = 1'b0;
        for (int c = 0; c < 13; c++) begin
            beat = (c < 3) ? c : ((c < 8) ? 3 : c - 5);
            ordy = !(c >= 3 && c < 8);
            #1;
            checks++;
            if (ov_a !== 1'b1 || od_a !== w[beat*W +: W] || od_b !== w[(D-1-beat)*W +: W] ||
                ol_a !== (beat == D - 1)) begin
                failures++;
                $display("FAIL stall_c%0d got v=%b a=%h b=%h l=%b exp v=1 a=%h b=%h l=%b",
                         c, ov_a, od_a, od_b, ol_a, w[beat*W +: W], w[(D-1-beat)*W +: W], beat == D - 1);
            end
            step();
        end
        #1;
        checks++;
        if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
            failures++;
            $display("FAIL stall_end got ov=%b/%b exp 0/0", ov_a, ov_b);
        end
    endtask

    task automatic test_clear_mid();
        logic [D*W-1:0] w;
        w = rand_word();
        lv = 1'b1; ordy = 1'b1; ld = w;
        step();
        lv = 1'b0;
        for (int k = 0; k < 4; k++) step();
        clr = 1'b1;
        #1;
        checks++;
        if (od_a !== w[4*W +: W] || lr_a !== 1'b0) begin
            failures++;
            $display("FAIL clear_beat4 got d=%h lr=%b exp d=%h lr=0", od_a, lr_a, w[4*W +: W]);
        end
        step();
        clr = 1'b0;
        #1;
        checks++;
        if (ov_a !== 1'b0 || ov_b !== 1'b0 || ol_a !== 1'b0 || od_a !== 8'h00 || lr_a !== 1'b1) begin
            failures++;
            $display("FAIL clear_after got ov=%b/%b l=%b d=%h lr=%b exp 0/0 0 00 1", ov_a, ov_b, ol_a, od_a, lr_a);
        end
        lv = 1'b1; ld = 64'hFFFEFDFCFBFAF9F8;
        step();
        lv = 1'b0;
        #1;
        checks++;
        if (ov_a !== 1'b1 || od_a !== 8'hF8 || od_b !== 8'hFF) begin
            failures++;
            $display("FAIL clear_reload got v=%b a=%h b=%h exp v=1 a=f8 b=ff", ov_a, od_a, od_b);
        end
        for (int k = 0; k < D; k++) step();
    endtask

    task automatic test_back_to_back();
        logic [D*W-1:0] w1, w2;
        int gaps;
        bit seen;
        w1 = rand_word(); w2 = rand_word();
        lv = 1'b1; ordy = 1'b1; ld = w1;
        step();
        lv = 1'b0;
        for (int k = 0; k < D - 1; k++) step();
        lv = 1'b1; ld = w2;
        #1;
        checks++;
        if (ol_a !== 1'b1 || od_a !== w1[(D-1)*W +: W] || lr_a !== B2B) begin
            failures++;
            $display("FAIL b2b_last got l=%b d=%h lr=%b exp l=1 d=%h lr=%b", ol_a, od_a, lr_a, w1[(D-1)*W +: W], B2B);
        end
        step();
        gaps = 0; seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            #1;
            if (ov_a === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (od_a !== w2[W-1:0] || od_b !== w2[(D-1)*W +: W]) begin
                    failures++;
                    $display("FAIL b2b_first got a=%h b=%h exp a=%h b=%h", od_a, od_b, w2[W-1:0], w2[(D-1)*W +: W]);
                end
            end else begin
                gaps++;
                step();
            end
        end
        lv = 1'b0;
        checks++;
        if (!seen || gaps != (B2B ? 0 : 1)) begin
            failures++;
            $display("FAIL b2b_gap got seen=%b gaps=%0d exp seen=1 gaps=%0d", seen, gaps, B2B ? 0 : 1);
        end
        for (int k = 0; k < D; k++) step();
    endtask

    task automatic test_load_ignored();
        logic [D*W-1:0] w;
        logic [W-1:0]   got[$];
        w = rand_word();
        lv = 1'b1; ordy = 1'b1; ld = w;
        step();
        for (int c = 0; c < 64 && got.size() < D; c++) begin
            ordy = 1'($urandom);
            lv   = (m_k < D - 1);
            ld   = rand_word();
            #1;
            if (lv) begin
                checks++;
                if (lr_a !== 1'b0 || lr_b !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_ready got %b/%b exp 0/0", lr_a, lr_b);
                end
            end
            if (ov_a === 1'b1 && ordy) got.push_back(od_a);
            step();
        end
        lv = 1'b0;
        checks++;
        if (got.size() != D) begin
            failures++;
            $display("FAIL ignore_count got %0d beats exp %0d", got.size(), D);
        end else begin
            for (int k = 0; k < D; k++) begin
                checks++;
                if (got[k] !== w[k*W +: W]) begin
                    failures++;
                    $display("FAIL ignore_beat%0d got %h exp %h", k, got[k], w[k*W +: W]);
                end
            end
        end
        for (int k = 0; k < D + 2; k++) begin
            ordy = 1'b1;
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            clr  = ($urandom_range(0, 39) == 0);
            lv   = 1'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            ld   = rand_word();
            #1;
            checks++;
            if ({ov_a, od_a, ol_a, lr_a, ov_b, od_b, ol_b, lr_b} !==
                {m_held, m_elem(1'b1), m_last(), m_lready(), m_held, m_elem(1'b0), m_last(), m_lready()}) begin
                failures++;
                $display("FAIL random_c%0d got a=%b/%h/%b/%b b=%b/%h/%b/%b exp a=%b/%h/%b/%b b=%b/%h/%b/%b",
                         c, ov_a, od_a, ol_a, lr_a, ov_b, od_b, ol_b, lr_b,
                         m_held, m_elem(1'b1), m_last(), m_lready(), m_held, m_elem(1'b0), m_last(), m_lready());
            end
            step();
        end
        clr = 1'b0; lv = 1'b0;
    endtask

    initial begin
        clr = 1'b1; lv = 1'b0; ordy = 1'b0; ld = '0;
        test_reset();
        test_order();
        test_stall();
        test_clear_mid();
        test_back_to_back();
        test_load_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
